// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte requesters.
// Issues a one-cycle send pulse, then blocks for a frame plus guard gap.
//
// state  | meaning
// IDLE   | waiting for any req_valid, grants one requester per cycle
// LAUNCH | tx_send high for this single cycle, tx_data presented
// WAIT   | uart_tx shifting the frame out (FRAME_CYCLES clocks)
// GAP    | guard idle time before the next grant (GAP_CYCLES clocks)
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int ID_W         = 2,
   parameter int FRAME_CYCLES = 10,
   parameter int GAP_CYCLES   = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 tx_send,
   output logic [7:0]           tx_data,
   output logic                 busy,
   output logic [ID_W-1:0]      grant_id,
   output logic [7:0]           tx_count
);

   localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_GAP
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [ID_W-1:0]   last;
   logic [ID_W-1:0]   win, win_hi, win_lo;
   logic              found_hi, any_valid;
   logic [7:0]        win_data;
   logic              accept;

   // Lowest valid index above the last grant wins; otherwise wrap to the lowest valid.
   always_comb begin
      win_hi    = '0;
      win_lo    = '0;
      found_hi  = 1'b0;
      any_valid = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            win_lo    = ID_W'(i);
            any_valid = 1'b1;
            if (ID_W'(i) > last) begin
               win_hi   = ID_W'(i);
               found_hi = 1'b1;
            end
         end
      end
      win      = found_hi ? win_hi : win_lo;
      win_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (ID_W'(i) == win) win_data = req_data[8*i +: 8];
      end
   end

   assign accept    = rstn && (state == S_IDLE) && any_valid;
   assign req_ready = accept ? (N_REQ'(1) << win) : '0;
   assign busy      = (state != S_IDLE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (any_valid) state_nxt = S_LAUNCH;
         end
         S_LAUNCH: begin
            state_nxt = S_WAIT;
            cnt_nxt   = FRAME_LOAD;
         end
         S_WAIT: begin
            if (cnt == '0) begin
               if (GAP_CYCLES == 0) begin
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_GAP;
                  cnt_nxt   = GAP_LOAD;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_GAP: begin
            if (cnt == '0) state_nxt = S_IDLE;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Send, data, grant and count are all registered at the accept edge so they
   // appear together during LAUNCH.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= S_IDLE;
         cnt      <= '0;
         last     <= ID_W'(N_REQ - 1);
         tx_send  <= 1'b0;
         tx_data  <= '0;
         grant_id <= '0;
         tx_count <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         tx_send <= accept;
         if (accept) begin
            tx_data  <= win_data;
            grant_id <= win;
            last     <= win;
            tx_count <= tx_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// traffic compared against a frame-level round-robin reference model.
module tb_uart_tx_arbiter;

   localparam int N    = 4;
   localparam int ID_W = 2;
   localparam int F    = 10;
   localparam int G    = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rstn;
   logic [N-1:0]    req_valid;
   logic [8*N-1:0]  req_data;
   logic [N-1:0]    req_ready;
   logic            tx_send;
   logic [7:0]      tx_data;
   logic            busy;
   logic [ID_W-1:0] grant_id;
   logic [7:0]      tx_count;

   logic [N-1:0]    req_valid0;
   logic [8*N-1:0]  req_data0;
   logic [N-1:0]    req_ready0;
   logic            tx_send0;
   logic [7:0]      tx_data0;
   logic            busy0;
   logic [ID_W-1:0] grant_id0;
   logic [7:0]      tx_count0;

   uart_tx_arbiter #(.N_REQ(N), .ID_W(ID_W), .FRAME_CYCLES(F), .GAP_CYCLES(G)) u_dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_send(tx_send), .tx_data(tx_data), .busy(busy),
      .grant_id(grant_id), .tx_count(tx_count)
   );

   uart_tx_arbiter #(.N_REQ(N), .ID_W(ID_W), .FRAME_CYCLES(F), .GAP_CYCLES(0)) u_dut_gap0 (
      .clk(clk), .rstn(rstn), .req_valid(req_valid0), .req_data(req_data0),
      .req_ready(req_ready0), .tx_send(tx_send0), .tx_data(tx_data0), .busy(busy0),
      .grant_id(grant_id0), .tx_count(tx_count0)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: a frame occupies the transmitter for 2+F+G clocks from the accept edge.
   int         m_left, m_last, m_count, m_grant;
   logic [7:0] m_data;
   logic       m_send;

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      int p;
      r = '0;
      p = rr_pick(req_valid, m_last);
      if (rstn && m_left == 0 && p >= 0) r[p] = 1'b1;
      return r;
   endfunction

   task automatic tick();
      int p;
      if (!rstn) begin
         m_left = 0; m_last = N - 1; m_count = 0; m_grant = 0; m_data = '0; m_send = 1'b0;
      end else begin
         m_send = 1'b0;
         if (m_left > 0) begin
            m_left--;
         end else begin
            p = rr_pick(req_valid, m_last);
            if (p >= 0) begin
               m_data  = req_data[8*p +: 8];
               m_grant = p;
               m_last  = p;
               m_left  = 1 + F + G;
               m_send  = 1'b1;
               m_count = (m_count + 1) % 256;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rstn = 1'b0; req_valid = '1; req_data = '0; req_valid0 = '0; req_data0 = '0;
      repeat (3) tick();
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
      checks++; if (tx_send !== 1'b0) begin errors++; $display("FAIL reset_send: got %b expected 0", tx_send); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
      checks++; if (tx_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", tx_count); end
      req_valid = '0;
      rstn = 1'b1;
      repeat (5) begin
         tick();
         checks++;
         if (busy !== 1'b0 || tx_send !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy=%b send=%b expected 0/0", busy, tx_send);
         end
      end
   endtask

   task automatic test_single();
      int n, sends;
      req_data[23:16] = 8'h41;
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
      tick();
      req_valid = '0;
      checks++; if (tx_send !== 1'b1) begin errors++; $display("FAIL single_send: got %b expected 1", tx_send); end
      checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data: got %h expected 41", tx_data); end
      checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d expected 2", grant_id); end
      checks++; if (tx_count !== 8'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", tx_count); end
      n = 0; sends = 0;
      for (int c = 0; c < 40 && busy === 1'b1; c++) begin
         n++;
         if (tx_send === 1'b1) sends++;
         tick();
      end
      checks++; if (n != 12) begin errors++; $display("FAIL single_busy_len: got %0d expected 12", n); end
      checks++; if (sends != 1) begin errors++; $display("FAIL single_send_once: got %0d expected 1", sends); end
   endtask

   task automatic test_all_valid();
      int t_prev;
      rstn = 1'b0; tick(); rstn = 1'b1;
      req_data = 32'h33323130;
      req_valid = 4'b1111;
      t_prev = 0;
      for (int s = 0; s < 5; s++) begin
         for (int c = 0; c < 20 && tx_send !== 1'b1; c++) tick();
         checks++;
         if (tx_send !== 1'b1) begin
            errors++; $display("FAIL all_valid_timeout: send %0d got no tx_send expected 1", s);
         end else begin
            checks++;
            if (tx_data !== 8'(8'h30 + (s % 4))) begin
               errors++; $display("FAIL all_valid_data: got %h expected %h", tx_data, 8'(8'h30 + (s % 4)));
            end
            if (s > 0) begin
               checks++;
               if (cyc - t_prev != 13) begin
                  errors++; $display("FAIL all_valid_spacing: got %0d expected 13", cyc - t_prev);
               end
            end
            t_prev = cyc;
         end
         if (s == 4) req_valid = '0;
         tick();
      end
      for (int c = 0; c < 20 && busy === 1'b1; c++) tick();
   endtask

   task automatic test_rr_order();
      logic [N-1:0] rows [6];
      int           want [6];
      rows = '{4'b0010, 4'b1010, 4'b0010, 4'b1000, 4'b1001, 4'b1000};
      want = '{1, 3, 1, 3, 0, 3};
      req_data = 32'hD3D2D1D0;
      for (int r = 0; r < 6; r++) begin
         req_valid = rows[r];
         for (int c = 0; c < 20 && tx_send !== 1'b1; c++) tick();
         checks++;
         if (tx_send !== 1'b1) begin
            errors++; $display("FAIL rr_timeout: row %0d no tx_send expected 1", r);
         end else begin
            checks++;
            if (grant_id !== ID_W'(want[r]) || grant_id !== ID_W'(m_grant)) begin
               errors++; $display("FAIL rr_grant: row %0d got %0d expected %0d", r, grant_id, want[r]);
            end
            checks++;
            if (tx_data !== 8'(8'hD0 + want[r])) begin
               errors++; $display("FAIL rr_data: row %0d got %h expected %h", r, tx_data, 8'(8'hD0 + want[r]));
            end
         end
         req_valid[want[r]] = 1'b0;
         tick();
      end
      req_valid = '0;
      for (int c = 0; c < 20 && busy === 1'b1; c++) tick();
   endtask

   task automatic test_reset_mid();
      req_data = 32'hD3D2D1D0;
      req_valid = 4'b0001;
      for (int c = 0; c < 20 && tx_send !== 1'b1; c++) tick();
      checks++; if (tx_send !== 1'b1) begin errors++; $display("FAIL midrst_first_send: got %b expected 1", tx_send); end
      req_valid = 4'b0100;
      repeat (4) tick();
      rstn = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      checks++; if (tx_send !== 1'b0) begin errors++; $display("FAIL midrst_send: got %b expected 0", tx_send); end
      checks++; if (tx_count !== 8'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", tx_count); end
      rstn = 1'b1;
      req_valid = 4'b0101;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_ready: got %b expected 0001", req_ready); end
      tick();
      req_valid = 4'b0100;
      checks++;
      if (tx_send !== 1'b1 || grant_id !== 2'd0 || tx_data !== 8'hD0) begin
         errors++; $display("FAIL midrst_regrant: send=%b grant=%0d data=%h expected 1/0/d0", tx_send, grant_id, tx_data);
      end
      for (int c = 0; c < 40 && !(busy === 1'b0 && req_valid == '0); c++) begin
         if (req_ready !== '0) req_valid = '0;
         tick();
      end
   endtask

   task automatic test_random();
      logic [N-1:0] er;
      for (int c = 0; c < 600; c++) begin
         rstn = ($urandom_range(0, 149) != 0);
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i]) begin
               req_data[8*i +: 8] = 8'($urandom);
               if ($urandom_range(0, 3) == 0) req_valid[i] = 1'b1;
            end else if ($urandom_range(0, 31) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         #1;
         er = exp_ready();
         checks++;
         if (req_ready !== er) begin
            errors++; $display("FAIL rand_ready: cycle %0d got %b expected %b", c, req_ready, er);
         end
         tick();
         checks++;
         if (tx_send !== m_send || tx_data !== m_data || grant_id !== ID_W'(m_grant) ||
             tx_count !== 8'(m_count) || busy !== (m_left != 0)) begin
            errors++;
            $display("FAIL rand_outputs: cycle %0d got send=%b data=%h grant=%0d count=%0d busy=%b expected %b/%h/%0d/%0d/%b",
                     c, tx_send, tx_data, grant_id, tx_count, busy, m_send, m_data, m_grant, m_count, (m_left != 0));
         end
         req_valid = req_valid & ~er;
      end
      rstn = 1'b1;
      req_valid = '0;
      for (int c = 0; c < 20 && busy === 1'b1; c++) tick();
   endtask

   task automatic test_gap0();
      int t_prev;
      req_data0[7:0] = 8'h5A;
      req_valid0 = 4'b0001;
      t_prev = 0;
      for (int s = 0; s < 256; s++) begin
         for (int c = 0; c < 20 && tx_send0 !== 1'b1; c++) tick();
         checks++;
         if (tx_send0 !== 1'b1) begin
            errors++; $display("FAIL gap0_timeout: send %0d no tx_send expected 1", s);
            break;
         end
         if (s > 0) begin
            checks++;
            if (cyc - t_prev != 12) begin
               errors++; $display("FAIL gap0_spacing: got %0d expected 12", cyc - t_prev);
            end
         end
         t_prev = cyc;
         if (s == 254) begin
            checks++;
            if (tx_count0 !== 8'd255) begin errors++; $display("FAIL gap0_count255: got %0d expected 255", tx_count0); end
         end
         tick();
      end
      req_valid0 = '0;
      checks++; if (tx_count0 !== 8'd0) begin errors++; $display("FAIL gap0_wrap: got %0d expected 0", tx_count0); end
      checks++; if (tx_data0 !== 8'h5A) begin errors++; $display("FAIL gap0_data: got %h expected 5a", tx_data0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_valid();
      test_rr_order();
      test_reset_mid();
      test_random();
      test_gap0();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
